// File: rtl/uart_cfg_sequencer_pkg.sv
// Shared types, status codes and config-word layout for the UART config sequencer.
package uart_cfg_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_QUIESCE,
    ST_WRITE,
    ST_SETTLE,
    ST_RESP
  } cfg_state_e;

  localparam logic [1:0] CFG_OK      = 2'b00;
  localparam logic [1:0] CFG_INVALID = 2'b01;
  localparam logic [1:0] CFG_TIMEOUT = 2'b10;

  // Field positions inside the 32-bit config word
  localparam int DIV_LSB   = 16;
  localparam int DIV_W     = 16;
  localparam int FSIZE_LSB = 13;
  localparam int FSIZE_W   = 3;
  localparam int DBITS_LSB = 4;
  localparam int DBITS_W   = 3;

  // Limits a word must respect to be accepted
  localparam logic [DIV_W-1:0]   MIN_DIVISOR   = 16'd16;
  localparam logic [DBITS_W-1:0] MAX_DATA_BITS = 3'd3;
  localparam logic [FSIZE_W-1:0] MAX_FIFO_SIZE = 3'd6;

  // Same rule uart_config applies; keep the two in lockstep through this function.
  function automatic logic cfg_is_valid(input logic [31:0] word);
    return (word[DIV_LSB +: DIV_W] >= MIN_DIVISOR) &&
           (word[DBITS_LSB +: DBITS_W] <= MAX_DATA_BITS) &&
           (word[FSIZE_LSB +: FSIZE_W] <= MAX_FIFO_SIZE);
  endfunction

endpackage

// File: rtl/uart_cfg_sequencer_if.sv
// Request/response handshake between the register slave and the config sequencer.
interface uart_cfg_sequencer_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_data;
  logic        resp_valid;
  logic [1:0]  resp_status;

  modport master (output req_valid, req_data, input req_ready, resp_valid, resp_status);
  modport slave  (input req_valid, req_data, output req_ready, resp_valid, resp_status);
endinterface

// File: rtl/uart_cfg_sequencer.sv
// Validates a config word, quiesces the UART datapath, writes uart_config and reports status.
module uart_cfg_sequencer
  import uart_cfg_sequencer_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 reset,
  uart_cfg_sequencer_if.slave  cfg,
  input  logic                 tx_busy,
  input  logic                 rx_busy,
  output logic                 uart_hold,
  output logic                 config_write,
  output logic [31:0]          config_data,
  output logic                 busy
);

  localparam int TO_W = ($clog2(TIMEOUT_CYCLES + 1) < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam int SC_W = ($clog2(SETTLE_CYCLES + 1) < 1) ? 1 : $clog2(SETTLE_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [SC_W-1:0] SC_LAST = SC_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

  cfg_state_e      state, state_n;
  logic [1:0]      status_n;
  logic [31:0]     cap;
  logic [TO_W-1:0] to_cnt;
  logic [SC_W-1:0] st_cnt;
  logic            accept;

  assign accept = cfg.req_valid && cfg.req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_n;
  end

  // Next state and the status that goes out with the response
  always_comb begin
    state_n  = state;
    status_n = CFG_OK;
    case (state)
      ST_IDLE:    if (accept) state_n = ST_CHECK;
      ST_CHECK: begin
        if (cfg_is_valid(cap)) begin
          state_n = ST_QUIESCE;
        end else begin
          state_n  = ST_RESP;
          status_n = CFG_INVALID;
        end
      end
      ST_QUIESCE: begin
        // Idle beats the terminal count when both land in the same cycle
        if (!tx_busy && !rx_busy) begin
          state_n = ST_WRITE;
        end else if (to_cnt >= TO_LAST) begin
          state_n  = ST_RESP;
          status_n = CFG_TIMEOUT;
        end
      end
      ST_WRITE:   state_n = (SETTLE_CYCLES == 0) ? ST_RESP : ST_SETTLE;
      ST_SETTLE:  if (st_cnt >= SC_LAST) state_n = ST_RESP;
      ST_RESP:    state_n = ST_IDLE;
      default:    state_n = ST_IDLE;
    endcase
  end

  // Capture the request word on accept
  always_ff @(posedge clk) begin
    if (reset)       cap <= '0;
    else if (accept) cap <= cfg.req_data;
  end

  // Quiesce timeout and settle counters, both saturating
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt <= '0;
      st_cnt <= '0;
    end else begin
      if (state == ST_CHECK)                          to_cnt <= '0;
      else if (state == ST_QUIESCE && to_cnt != '1)   to_cnt <= to_cnt + 1'b1;
      if (state == ST_WRITE)                          st_cnt <= '0;
      else if (state == ST_SETTLE && st_cnt != '1)    st_cnt <= st_cnt + 1'b1;
    end
  end

  // Registered outputs decoded from the next state so they line up with the state itself
  always_ff @(posedge clk) begin
    if (reset) begin
      cfg.req_ready   <= 1'b1;
      cfg.resp_valid  <= 1'b0;
      cfg.resp_status <= CFG_OK;
      uart_hold       <= 1'b0;
      config_write    <= 1'b0;
      config_data     <= '0;
      busy            <= 1'b0;
    end else begin
      cfg.req_ready   <= (state_n == ST_IDLE);
      cfg.resp_valid  <= (state_n == ST_RESP);
      cfg.resp_status <= (state_n == ST_RESP) ? status_n : CFG_OK;
      uart_hold       <= (state_n == ST_QUIESCE) || (state_n == ST_WRITE) || (state_n == ST_SETTLE);
      config_write    <= (state_n == ST_WRITE);
      if (state_n == ST_WRITE) config_data <= cap;
      busy            <= (state_n != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_uart_cfg_sequencer.sv
// Bench for uart_cfg_sequencer: vector table plus hand sequences, scoreboard-checked.
module tb_uart_cfg_sequencer;
  import uart_cfg_sequencer_pkg::*;

  localparam int SA = 16, TA = 1000;  // dut_a
  localparam int SB = 0,  TB = 8;     // dut_b

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_cfg_sequencer_if if_a();
  uart_cfg_sequencer_if if_b();

  logic tx_a = 0, rx_a = 0, hold_a, cw_a, busy_a;
  logic tx_b = 0, rx_b = 0, hold_b, cw_b, busy_b;
  logic [31:0] cd_a, cd_b;

  uart_cfg_sequencer #(.SETTLE_CYCLES(SA), .TIMEOUT_CYCLES(TA)) dut_a (
    .clk(clk), .reset(reset), .cfg(if_a.slave), .tx_busy(tx_a), .rx_busy(rx_a),
    .uart_hold(hold_a), .config_write(cw_a), .config_data(cd_a), .busy(busy_a));

  uart_cfg_sequencer #(.SETTLE_CYCLES(SB), .TIMEOUT_CYCLES(TB)) dut_b (
    .clk(clk), .reset(reset), .cfg(if_b.slave), .tx_busy(tx_b), .rx_busy(rx_b),
    .uart_hold(hold_b), .config_write(cw_b), .config_data(cd_b), .busy(busy_b));

  typedef struct {
    int          id;
    logic [31:0] data;
    logic [1:0]  status;
    bit          wr;
    int          wr_cyc;
    int          resp_cyc;
    int          hold;
  } sb_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          k;       // busy drops at negedge of accept cycle + k (0 = never busy)
    bit          use_rx;
    logic [1:0]  status;
  } vec_t;

  sb_t sb_q[$];
  int  checks = 0, errors = 0, resp_seen = 0, hold_cnt = 0;
  bit  wr_seen = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_req(int id, logic v, logic [31:0] d);
    if (id == 0) begin if_a.req_valid = v; if_a.req_data = d; end
    else         begin if_b.req_valid = v; if_b.req_data = d; end
  endtask

  task automatic drive_busy(int id, logic tx, logic rx);
    if (id == 0) begin tx_a = tx; rx_a = rx; end
    else         begin tx_b = tx; rx_b = rx; end
  endtask

  function automatic logic ready_of(int id);
    return (id == 0) ? if_a.req_ready : if_b.req_ready;
  endfunction

  // Expected timing from the accept cycle c, hand-derived from the state sequence
  function automatic sb_t make_entry(int id, logic [31:0] d, int k, logic [1:0] st, int c);
    sb_t e;
    int s, to, j;
    s  = (id == 0) ? SA : SB;
    to = (id == 0) ? TA : TB;
    e.id = id; e.data = d; e.status = st; e.wr = 0; e.wr_cyc = -1;
    if (st == CFG_INVALID) begin
      e.resp_cyc = c + 2; e.hold = 0;
    end else if (st == CFG_TIMEOUT) begin
      e.resp_cyc = c + 2 + to; e.hold = to;
    end else begin
      j = (k > 2) ? k : 2;
      e.wr = 1; e.wr_cyc = c + j + 1; e.resp_cyc = c + j + 2 + s; e.hold = j + s;
    end
    return e;
  endfunction

  task automatic mon(int id, logic rv, logic [1:0] rs, logic cw, logic [31:0] cd, logic hold);
    sb_t e;
    if (!(rv === 1'b1 || cw === 1'b1 || hold === 1'b1)) return;
    if (sb_q.size() == 0 || sb_q[0].id != id) begin
      checks++; errors++;
      $display("FAIL unexpected_activity dut%0d @cyc %0d: write=%0b resp=%0b hold=%0b, none expected",
               id, cyc, cw, rv, hold);
      return;
    end
    e = sb_q[0];
    if (hold) hold_cnt++;
    if (cw) begin
      check("write_expected", 32'(1), 32'(e.wr));
      check("write_cycle", cyc, e.wr_cyc);
      check("write_data", cd, e.data);
      wr_seen = 1;
    end
    if (rv) begin
      check("resp_status", 32'(rs), 32'(e.status));
      check("resp_cycle", cyc, e.resp_cyc);
      check("hold_at_resp", 32'(hold), 32'(0));
      check("hold_cycles", hold_cnt, e.hold);
      check("write_seen", 32'(wr_seen), 32'(e.wr));
      void'(sb_q.pop_front());
      hold_cnt = 0; wr_seen = 0; resp_seen++;
    end
  endtask

  // Output monitor, one step after each active edge
  initial forever begin
    @(posedge clk); #1;
    mon(0, if_a.resp_valid, if_a.resp_status, cw_a, cd_a, hold_a);
    mon(1, if_b.resp_valid, if_b.resp_status, cw_b, cd_b, hold_b);
  end

  task automatic expire(string name, int budget);
    checks++; errors++;
    $display("FAIL %s: no response within %0d cycles", name, budget);
    sb_q.delete(); hold_cnt = 0; wr_seen = 0;
  endtask

  task automatic run_txn(vec_t v);
    sb_t e;
    int c, target, budget;
    @(negedge clk);
    c = cyc;
    e = make_entry(v.id, v.data, v.k, v.status, c);
    sb_q.push_back(e);
    drive_busy(v.id, v.k > 0 && !v.use_rx, v.k > 0 && v.use_rx);
    drive_req(v.id, 1'b1, v.data);
    target = resp_seen + 1;
    budget = e.resp_cyc - c + 20;
    for (int n = 1; n <= budget && resp_seen < target; n++) begin
      @(negedge clk);
      if (n == 1) begin
        drive_req(v.id, 1'b0, v.data);
        check("ready_low_in_check", 32'(ready_of(v.id)), 32'(0));
      end
      if (cyc == c + v.k) drive_busy(v.id, 1'b0, 1'b0);
    end
    drive_busy(v.id, 1'b0, 1'b0);
    if (resp_seen < target) begin
      expire("txn_response", budget);
      resp_seen = target;
    end
    @(negedge clk);
    check("ready_after_resp", 32'(ready_of(v.id)), 32'(1));
  endtask

  task automatic check_reset_outs(int id, string tag);
    if (id == 0) begin
      check({tag, "_ready"},  32'(if_a.req_ready), 32'(1));
      check({tag, "_resp"},   32'(if_a.resp_valid), 32'(0));
      check({tag, "_status"}, 32'(if_a.resp_status), 32'(0));
      check({tag, "_hold"},   32'(hold_a), 32'(0));
      check({tag, "_write"},  32'(cw_a), 32'(0));
      check({tag, "_data"},   cd_a, 32'h0);
      check({tag, "_busy"},   32'(busy_a), 32'(0));
    end else begin
      check({tag, "_ready"},  32'(if_b.req_ready), 32'(1));
      check({tag, "_resp"},   32'(if_b.resp_valid), 32'(0));
      check({tag, "_status"}, 32'(if_b.resp_status), 32'(0));
      check({tag, "_hold"},   32'(hold_b), 32'(0));
      check({tag, "_write"},  32'(cw_b), 32'(0));
      check({tag, "_data"},   cd_b, 32'h0);
      check({tag, "_busy"},   32'(busy_b), 32'(0));
    end
  endtask

  task automatic reset_mid(int id, bit rx_stuck, int at, string tag);
    int c, r0;
    @(negedge clk);
    c = cyc;
    sb_q.push_back(make_entry(id, 32'h03635C30, 0, rx_stuck ? CFG_TIMEOUT : CFG_OK, c));
    drive_busy(id, 1'b0, rx_stuck);
    drive_req(id, 1'b1, 32'h03635C30);
    @(negedge clk);
    drive_req(id, 1'b0, 32'h03635C30);
    while (cyc < c + at) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_reset_outs(id, tag);
    sb_q.delete(); hold_cnt = 0; wr_seen = 0;
    drive_busy(id, 1'b0, 1'b0);
    r0 = resp_seen;
    repeat (30) @(negedge clk);
    check({tag, "_no_resp"}, resp_seen, r0);
  endtask

  vec_t tbl[13];

  initial begin
    int c, target;
    tbl[0]  = '{0, 32'h03635C30, 0,    0, CFG_OK};       // nominal, resp c20
    tbl[1]  = '{0, 32'h00085C30, 0,    0, CFG_INVALID};  // divisor 8
    tbl[2]  = '{0, 32'h03635C40, 0,    0, CFG_INVALID};  // data_bits 4
    tbl[3]  = '{0, 32'h0363FC30, 0,    0, CFG_INVALID};  // fifo_size 7
    tbl[4]  = '{0, 32'h000F5C30, 0,    0, CFG_INVALID};  // divisor 15
    tbl[5]  = '{0, 32'h00105C30, 0,    0, CFG_OK};       // divisor 16
    tbl[6]  = '{0, 32'h0010DC30, 0,    0, CFG_OK};       // fifo_size 6
    tbl[7]  = '{0, 32'h03635C30, 50,   0, CFG_OK};       // tx busy 50 cycles
    tbl[8]  = '{0, 32'h12345C30, 5,    1, CFG_OK};       // rx busy 5 cycles
    tbl[9]  = '{1, 32'h03635C30, 0,    0, CFG_OK};       // no settle phase
    tbl[10] = '{1, 32'h03635C30, 9,    1, CFG_OK};       // idle at terminal count
    tbl[11] = '{1, 32'h03635C30, 10,   1, CFG_TIMEOUT};  // one cycle too late
    tbl[12] = '{1, 32'h03635C30, 1000, 1, CFG_TIMEOUT};  // rx stuck

    drive_req(0, 1'b0, 32'h0);
    drive_req(1, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    check_reset_outs(0, "reset_a");
    check_reset_outs(1, "reset_b");
    reset = 1'b0;

    for (int i = 0; i < 13; i++) run_txn(tbl[i]);

    // Requester holds valid through the whole transaction; the second word is
    // only picked up in the IDLE cycle after RESP.
    @(negedge clk);
    c = cyc;
    sb_q.push_back(make_entry(0, 32'h03635C30, 0, CFG_OK, c));
    sb_q.push_back(make_entry(0, 32'h00085C30, 0, CFG_INVALID, c + 21));
    drive_req(0, 1'b1, 32'h03635C30);
    target = resp_seen + 2;
    for (int n = 1; n <= 60 && resp_seen < target; n++) begin
      @(negedge clk);
      if (cyc == c + 20) drive_req(0, 1'b1, 32'h00085C30);
      if (cyc == c + 22) drive_req(0, 1'b0, 32'h0);
    end
    drive_req(0, 1'b0, 32'h0);
    if (resp_seen < target) begin
      expire("back_to_back", 60);
      resp_seen = target;
    end

    reset_mid(0, 1'b0, 10, "rst_settle");
    reset_mid(1, 1'b1, 5,  "rst_quiesce");

    run_txn(tbl[0]);  // recovers after mid-operation reset

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
